// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload (HPS read-back) path.
package ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_READY = 3'd2,
    ST_FETCH = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // ioctl_index values used by the download/upload paths
  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [7:0] IDX_NVRAM = 8'd4;

  // Value presented on ioctl_din after reset and for out-of-window reads
  localparam logic [7:0] DIN_IDLE  = 8'hFF;

endpackage

// File: rtl/upload_latency_ctr.sv
// Down-counter that times the core RAM read latency; zero_o marks the
// cycle in which read data is valid.
module upload_latency_ctr #(
  parameter int MAX = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic clear_i,
  output logic zero_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  // load to MAX, then count down to zero and hold there
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(MAX);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload reads (hiscore / NVRAM save) from the core's byte RAM.
// The core CPU is paused before any RAM access; each ioctl_rd fetches one
// byte that appears on ioctl_din RD_LATENCY+1 cycles later.
//
// state | meaning
// IDLE  | no session; ioctl_rd ignored
// PAUSE | pause_req raised, waiting for pause_ack; reads queue as pending
// READY | CPU halted, waiting for a read request (new or pending)
// FETCH | RAM read in flight; one further request can queue as pending
// ABORT | session ended; pending/in-flight work dropped, done next cycle
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int RD_LATENCY   = 2,
  parameter int UPLOAD_INDEX = 4
) (
  input  logic              clk_sys_i,
  input  logic              reset_i,
  input  logic              ioctl_upload_i,
  input  logic [7:0]        ioctl_index_i,
  input  logic              ioctl_rd_i,
  input  logic [24:0]       ioctl_addr_i,
  output logic [7:0]        ioctl_din_o,
  output logic              pause_req_o,
  input  logic              pause_ack_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_dout_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [7:0]          din_q, din_d;
  logic                pause_req_q, pause_req_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;
  logic [24:0]         pend_addr_q, pend_addr_d;
  logic [24:0]         req_addr;
  logic                ctr_load, ctr_clear, ctr_zero;
  logic                sel;

  assign sel = ioctl_upload_i && (ioctl_index_i == 8'(UPLOAD_INDEX));

  upload_latency_ctr #(.MAX(RD_LATENCY)) u_lat_ctr (
    .clk_i   (clk_sys_i),
    .reset_i (reset_i),
    .load_i  (ctr_load),
    .clear_i (ctr_clear),
    .zero_o  (ctr_zero)
  );

  // next-state and datapath decisions for the session FSM
  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    pause_req_d = pause_req_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ctr_load    = 1'b0;
    ctr_clear   = 1'b0;
    // a queued request is always older than one arriving now
    req_addr    = pend_q ? pend_addr_q : ioctl_addr_i;

    if (state_q != ST_IDLE && state_q != ST_ABORT && !sel) begin
      state_d     = ST_ABORT;
      pause_req_d = 1'b0;
      pend_d      = 1'b0;
      ctr_clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel) begin
            state_d     = ST_PAUSE;
            pause_req_d = 1'b1;
            err_d       = 1'b0;
          end
        end
        ST_PAUSE, ST_FETCH: begin
          if (ioctl_rd_i) begin
            if (pend_q) begin
              err_d = 1'b1;
            end else begin
              pend_d      = 1'b1;
              pend_addr_d = ioctl_addr_i;
            end
          end
          if (state_q == ST_PAUSE && pause_ack_i) begin
            state_d = ST_READY;
          end
          if (state_q == ST_FETCH && ctr_zero) begin
            din_d   = mem_dout_i;
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (pend_q || ioctl_rd_i) begin
            // serving the pending slot frees it for a strobe arriving now
            if (pend_q && ioctl_rd_i) begin
              pend_addr_d = ioctl_addr_i;
            end else begin
              pend_d = 1'b0;
            end
            if (~|req_addr[24:ADDR_W]) begin
              mem_addr_d = req_addr[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              ctr_load   = 1'b1;
              state_d    = ST_FETCH;
            end else begin
              din_d = DIN_IDLE;
              err_d = 1'b1;
            end
          end
        end
        ST_ABORT: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      din_q       <= DIN_IDLE;
      pause_req_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      pause_req_q <= pause_req_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign ioctl_din_o = din_q;
  assign pause_req_o = pause_req_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: directed session scenarios plus a random
// read phase, checked against a transaction-level expectation of ioctl_din,
// err and the number of RAM reads.
module tb_ioctl_upload_reader;

  localparam int ADDR_W = 10;
  localparam int L      = 2;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_upload = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_rd = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_din;
  logic              pause_req;
  logic              pause_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_dout;
  logic              busy;
  logic              done;
  logic              err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;
  logic exp_err  = 1'b0;

  logic [7:0] ram  [NWORDS];
  logic [7:0] pipe [L];

  ioctl_upload_reader #(
    .ADDR_W(ADDR_W), .RD_LATENCY(L), .UPLOAD_INDEX(4)
  ) dut (
    .clk_sys_i      (clk_sys),
    .reset_i        (reset),
    .ioctl_upload_i (ioctl_upload),
    .ioctl_index_i  (ioctl_index),
    .ioctl_rd_i     (ioctl_rd),
    .ioctl_addr_i   (ioctl_addr),
    .ioctl_din_o    (ioctl_din),
    .pause_req_o    (pause_req),
    .pause_ack_i    (pause_ack),
    .mem_addr_o     (mem_addr),
    .mem_rd_o       (mem_rd),
    .mem_dout_i     (mem_dout),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  always #5 clk_sys = ~clk_sys;

  // core RAM: data valid for exactly one cycle, L cycles after mem_rd
  always @(posedge clk_sys) begin
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'h00;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end
  assign mem_dout = pipe[L-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_din(input logic [7:0] v, input int maxc, input string tag);
    int n;
    n = 0;
    while (ioctl_din !== v && n < maxc) begin
      step();
      n++;
    end
    check_val(tag, ioctl_din, v);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_din"},   ioctl_din, 8'hFF);
    check_val({tag, "_preq"},  pause_req, 0);
    check_val({tag, "_mrd"},   mem_rd, 0);
    check_val({tag, "_maddr"}, mem_addr, 0);
    check_val({tag, "_busy"},  busy, 0);
    check_val({tag, "_done"},  done, 0);
    check_val({tag, "_err"},   err, 0);
  endtask

  task automatic start_session();
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    step();
    check_val("start_preq", pause_req, 1);
    check_val("start_busy", busy, 1);
    check_val("start_err",  err, 0);
    exp_err = 1'b0;
    step();
    step();
    check_val("pause_hold", pause_req, 1);
    pause_ack = 1'b1;
    step();
  endtask

  // single read in READY; expected din is ram[a] exactly L+1 cycles later
  task automatic do_read(input logic [24:0] a);
    logic [7:0] prev;
    int c0;
    prev = ioctl_din;
    c0   = rd_cnt;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    if (a < 25'(NWORDS)) begin
      check_val("rd_pulse", mem_rd, 1);
      check_val("rd_addr",  mem_addr, 32'(a));
      for (int k = 0; k < L; k++) begin
        step();
        check_val("din_hold", ioctl_din, prev);
      end
      step();
      check_val("din_data", ioctl_din, ram[a[ADDR_W-1:0]]);
      check_val("rd_once",  rd_cnt - c0, 1);
    end else begin
      exp_err = 1'b1;
      check_val("oor_rd",  mem_rd, 0);
      check_val("oor_din", ioctl_din, 8'hFF);
      step();
      check_val("oor_norw", rd_cnt - c0, 0);
    end
    check_val("rd_err", err, exp_err);
  endtask

  initial begin
    logic [24:0] a;
    logic [7:0]  prev;
    int c0;

    for (int i = 0; i < NWORDS; i++) ram[i] = 8'($urandom);
    for (int k = 0; k < L; k++) pipe[k] = 8'h00;
    ram[10'h012] = 8'hA5;
    ram[10'h010] = 8'h11;
    ram[10'h011] = 8'h22;
    ram[10'h020] = 8'h33;
    ram[10'h021] = 8'h44;
    ram[10'h022] = 8'h55;

    repeat (3) step();
    reset = 1'b0;
    check_reset_vals("rst");

    // session 1
    start_session();
    do_read(25'h012);

    // two back-to-back strobes: second waits in the pending slot
    c0 = rd_cnt;
    ioctl_addr = 25'h010; ioctl_rd = 1'b1; step();
    ioctl_addr = 25'h011; step();
    ioctl_rd = 1'b0; step(); step();
    check_val("b2b_first", ioctl_din, 8'h11);
    wait_din(8'h22, 10, "b2b_second");
    check_val("b2b_err", err, 0);
    check_val("b2b_rds", rd_cnt - c0, 2);

    // three strobes: the third finds the slot full and is dropped
    c0 = rd_cnt;
    ioctl_addr = 25'h020; ioctl_rd = 1'b1; step();
    ioctl_addr = 25'h021; step();
    ioctl_addr = 25'h022; step();
    ioctl_rd = 1'b0; step();
    check_val("drop_first", ioctl_din, 8'h33);
    wait_din(8'h44, 10, "drop_second");
    repeat (8) step();
    check_val("drop_keep", ioctl_din, 8'h44);
    check_val("drop_rds",  rd_cnt - c0, 2);
    check_val("drop_err",  err, 1);
    exp_err = 1'b1;

    do_read(25'h400);

    // random read phase
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 4) == 0)
        a = {15'($urandom_range(1, 32767)), 10'($urandom)};
      else
        a = 25'($urandom_range(0, NWORDS - 1));
      do_read(a);
    end

    // clean session end
    ioctl_upload = 1'b0;
    step();
    check_val("end_preq", pause_req, 0);
    check_val("end_done0", done, 0);
    step();
    check_val("end_done", done, 1);
    check_val("end_busy", busy, 0);
    step();
    check_val("end_done_1cyc", done, 0);
    pause_ack = 1'b0;

    // session 2: read issued while still pausing, then abort mid-fetch
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    step();
    check_val("s2_preq", pause_req, 1);
    check_val("s2_err_clr", err, 0);
    exp_err = 1'b0;
    a = 25'h155;
    ram[a[ADDR_W-1:0]] = ~ioctl_din;
    c0 = rd_cnt;
    ioctl_addr = a; ioctl_rd = 1'b1; step();
    ioctl_rd = 1'b0; step();
    check_val("pause_no_rd", rd_cnt - c0, 0);
    pause_ack = 1'b1; step();
    wait_din(ram[a[ADDR_W-1:0]], 10, "pend_pause");
    check_val("pend_pause_rds", rd_cnt - c0, 1);

    prev = ioctl_din;
    a = 25'h2AB;
    ram[a[ADDR_W-1:0]] = ~prev;
    ioctl_addr = a; ioctl_rd = 1'b1; step();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    step();
    check_val("abort_preq", pause_req, 0);
    check_val("abort_busy", busy, 1);
    check_val("abort_done0", done, 0);
    step();
    check_val("abort_done", done, 1);
    check_val("abort_idle", busy, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("abort_din", ioctl_din, prev);
    end
    check_val("abort_done_1cyc", done, 0);
    pause_ack = 1'b0;

    // wrong index: nothing happens
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd0;
    repeat (3) step();
    check_val("widx_preq", pause_req, 0);
    check_val("widx_busy", busy, 0);
    c0 = rd_cnt;
    ioctl_addr = 25'h012; ioctl_rd = 1'b1; step();
    ioctl_rd = 1'b0; step(); step();
    check_val("widx_nord", rd_cnt - c0, 0);
    check_val("widx_din", ioctl_din, prev);
    ioctl_upload = 1'b0;
    step();

    // session 3: reset during a fetch with err already set
    start_session();
    do_read(25'h1_0000);
    ioctl_addr = 25'h033; ioctl_rd = 1'b1; step();
    ioctl_rd = 1'b0;
    check_val("s3_fetch_rd", mem_rd, 1);
    reset = 1'b1; ioctl_upload = 1'b0; pause_ack = 1'b0;
    step();
    check_reset_vals("midrst");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("midrst_nodone", done, 0);
      check_val("midrst_din", ioctl_din, 8'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
